// File: rtl/pwm_ramp_sequencer.sv
// Ramps four PWM duty registers toward their targets over an AXI4-Lite master, one step per tick.
// Latency: a tick starts a scan on the next edge; each differing channel costs SCAN + WRITE + RESP cycles.
// Backpressure: one outstanding write; VALIDs are held until the slave handshakes; ticks during a scan are dropped.
module pwm_ramp_sequencer #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_PWM_BASEADDR = 32'h0000_0000
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic                          tgt_valid,
    output logic                          tgt_ready,
    input  logic [1:0]                    tgt_ch,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] tgt_duty,
    input  logic [15:0]                   step,
    input  logic                          tick,
    input  logic                          err_clr,
    output logic                          busy,
    output logic                          bresp_err,
    output logic                          overrun,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, SCAN, WRITE, RESP} state_t;

    state_t          state;
    logic [1:0]      ch_idx;
    logic [DW-1:0]   cur [4];
    logic [DW-1:0]   tgt [4];
    logic [DW-1:0]   nxt_q;
    logic [DW-1:0]   nxt_c;
    logic [DW:0]     cur_x;
    logic [DW:0]     tgt_x;
    logic [DW:0]     diff;
    logic [DW:0]     step_x;
    logic [DW-1:0]   step_w;
    logic [AW-1:0]   ch_addr;
    logic            last_ch;
    logic            aw_ok;
    logic            w_ok;
    logic            ovr_set;
    logic            berr_set;

    assign tgt_ready    = 1'b1;
    assign busy         = (state != IDLE);
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_WSTRB  = 4'hF;

    assign last_ch = (ch_idx == 2'd3);
    assign ch_addr = C_PWM_BASEADDR + {{(AW-4){1'b0}}, ch_idx, 2'b00};
    assign aw_ok   = !M_AXI_AWVALID || M_AXI_AWREADY;
    assign w_ok    = !M_AXI_WVALID  || M_AXI_WREADY;

    assign ovr_set  = tick && (state != IDLE);
    assign berr_set = (state == RESP) && M_AXI_BREADY && M_AXI_BVALID && (M_AXI_BRESP != 2'b00);

    // Distance is taken in one extra bit so the step comparison never wraps.
    always_comb begin
        cur_x  = {1'b0, cur[ch_idx]};
        tgt_x  = {1'b0, tgt[ch_idx]};
        step_w = {{(DW-16){1'b0}}, step};
        step_x = {1'b0, step_w};
        diff   = (tgt_x > cur_x) ? (tgt_x - cur_x) : (cur_x - tgt_x);
        nxt_c  = tgt[ch_idx];
        if (step != 16'd0 && diff > step_x) begin
            if (tgt_x > cur_x)
                nxt_c = cur[ch_idx] + step_w;
            else
                nxt_c = cur[ch_idx] - step_w;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < 4; i++) tgt[i] <= '0;
        end else if (tgt_valid) begin
            tgt[tgt_ch] <= tgt_duty;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state         <= IDLE;
            ch_idx        <= '0;
            nxt_q         <= '0;
            M_AXI_AWADDR  <= '0;
            M_AXI_WDATA   <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            for (int i = 0; i < 4; i++) cur[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        state  <= SCAN;
                        ch_idx <= '0;
                    end
                end
                SCAN: begin
                    if (cur[ch_idx] == tgt[ch_idx]) begin
                        state  <= last_ch ? IDLE : SCAN;
                        ch_idx <= ch_idx + 2'd1;
                    end else begin
                        nxt_q         <= nxt_c;
                        M_AXI_AWADDR  <= ch_addr;
                        M_AXI_WDATA   <= nxt_c;
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID  <= 1'b1;
                        state         <= WRITE;
                    end
                end
                WRITE: begin
                    if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WVALID && M_AXI_WREADY)   M_AXI_WVALID  <= 1'b0;
                    if (aw_ok && w_ok) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        // A failed write leaves cur alone so the next tick retries the same value.
                        if (M_AXI_BRESP == 2'b00) cur[ch_idx] <= nxt_q;
                        state  <= last_ch ? IDLE : SCAN;
                        ch_idx <= ch_idx + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A set event in the same cycle as err_clr keeps the flag raised.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            bresp_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (berr_set)     bresp_err <= 1'b1;
            else if (err_clr) bresp_err <= 1'b0;
            if (ovr_set)      overrun   <= 1'b1;
            else if (err_clr) overrun   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Directed bench for pwm_ramp_sequencer with a configurable AXI4-Lite write slave.
module tb_pwm_ramp_sequencer;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        tgt_valid = 1'b0;
    logic        tgt_ready;
    logic [1:0]  tgt_ch = 2'd0;
    logic [31:0] tgt_duty = 32'd0;
    logic [15:0] step = 16'd0;
    logic        tick = 1'b0;
    logic        err_clr = 1'b0;
    logic        busy;
    logic        bresp_err;
    logic        overrun;
    logic [31:0] M_AXI_AWADDR;
    logic [2:0]  M_AXI_AWPROT;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY = 1'b0;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY = 1'b0;
    logic [1:0]  M_AXI_BRESP = 2'b00;
    logic        M_AXI_BVALID = 1'b0;
    logic        M_AXI_BREADY;

    pwm_ramp_sequencer dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .tgt_valid(tgt_valid), .tgt_ready(tgt_ready), .tgt_ch(tgt_ch), .tgt_duty(tgt_duty),
        .step(step), .tick(tick), .err_clr(err_clr),
        .busy(busy), .bresp_err(bresp_err), .overrun(overrun),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY)
    );

    always #5 ACLK = ~ACLK;

    // Slave configuration (written by the stimulus) and monotonic observation counters.
    int          aw_delay = 0;
    int          w_delay = 0;
    logic [1:0]  bresp_cfg = 2'b00;
    int          aw_cnt = 0, w_cnt = 0;
    logic        aw_got = 1'b0, w_got = 1'b0, b_fire = 1'b0;
    logic [31:0] aw_cap = 0, w_cap = 0, aw_first = 0;
    int          aw_hi = 0, w_hi = 0, addr_bad = 0, bhs_cnt = 0;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    // Readies are decided on the falling edge; a ready raised with VALID high completes on the next rising edge.
    always @(negedge ACLK) begin
        if (!ARESETN) begin
            M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
            aw_cnt = 0; w_cnt = 0; aw_got = 1'b0; w_got = 1'b0; b_fire = 1'b0;
        end else begin
            if (b_fire) begin
                M_AXI_BVALID = 1'b0;
                b_fire = 1'b0;
                bhs_cnt++;
            end
            if (aw_got && w_got && !M_AXI_BVALID) begin
                M_AXI_BVALID = 1'b1;
                M_AXI_BRESP = bresp_cfg;
                aw_got = 1'b0;
                w_got = 1'b0;
                log_addr.push_back(aw_cap);
                log_data.push_back(w_cap);
            end
            if (M_AXI_BVALID && M_AXI_BREADY) b_fire = 1'b1;
            if (M_AXI_AWVALID && !aw_got) begin
                if (aw_cnt == 0) aw_first = M_AXI_AWADDR;
                else if (M_AXI_AWADDR != aw_first) addr_bad++;
                aw_hi++;
                M_AXI_AWREADY = (aw_cnt >= aw_delay);
                aw_cnt++;
                if (M_AXI_AWREADY) begin aw_got = 1'b1; aw_cap = M_AXI_AWADDR; end
            end else begin
                M_AXI_AWREADY = 1'b0;
                aw_cnt = 0;
            end
            if (M_AXI_WVALID && !w_got) begin
                w_hi++;
                M_AXI_WREADY = (w_cnt >= w_delay);
                w_cnt++;
                if (M_AXI_WREADY) begin w_got = 1'b1; w_cap = M_AXI_WDATA; end
            end else begin
                M_AXI_WREADY = 1'b0;
                w_cnt = 0;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
        logic [63:0] obs;
        obs = (idx < log_addr.size()) ? {log_addr[idx], log_data[idx]} : 64'hx;
        check(tag, obs, {a, d});
    endtask

    task automatic cyc();
        @(negedge ACLK);
        #1;
    endtask

    task automatic set_tgt(input logic [1:0] c, input logic [31:0] d);
        tgt_ch = c; tgt_duty = d; tgt_valid = 1'b1;
        cyc();
        tgt_valid = 1'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            cyc();
        end
        check(tag, busy, 1'b0);
    endtask

    task automatic wait_aw(input string tag);
        for (int i = 0; i < 50; i++) begin
            if (M_AXI_AWVALID) break;
            cyc();
        end
        check(tag, M_AXI_AWVALID, 1'b1);
    endtask

    task automatic run_tick(input string tag);
        pulse_tick();
        wait_idle(tag);
    endtask

    initial begin
        int b, bh, a0, w0, bad0;
        logic prev_busy;

        // Reset values
        repeat (3) cyc();
        check("rst_busy", busy, 1'b0);
        check("rst_flags", {bresp_err, overrun}, 2'b00);
        check("rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 3'b000);
        check("rst_awaddr", M_AXI_AWADDR, 32'h0);
        check("rst_wdata", M_AXI_WDATA, 32'h0);
        check("rst_tgt_ready", tgt_ready, 1'b1);
        check("const_prot_strb", {M_AXI_AWPROT, M_AXI_WSTRB}, 7'b000_1111);
        ARESETN = 1'b1;
        cyc();

        // Ramp ch0 0 -> 100 in steps of 30
        step = 16'd30;
        set_tgt(2'd0, 32'd100);
        b = log_addr.size();
        for (int k = 0; k < 4; k++) begin
            run_tick("ramp_idle");
            repeat (15) cyc();
        end
        check("ramp_nwr", log_addr.size() - b, 4);
        check_wr("ramp_w0", b + 0, 32'h0, 32'd30);
        check_wr("ramp_w1", b + 1, 32'h0, 32'd60);
        check_wr("ramp_w2", b + 2, 32'h0, 32'd90);
        check_wr("ramp_w3", b + 3, 32'h0, 32'd100);
        run_tick("ramp_idle5");
        check("ramp_5th_nowr", log_addr.size() - b, 4);
        check("ramp_flags", {bresp_err, overrun}, 2'b00);

        // Jump two channels in one tick; busy falls right after the last B handshake
        step = 16'd0;
        set_tgt(2'd1, 32'd50);
        set_tgt(2'd3, 32'd7);
        b = log_addr.size();
        bh = bhs_cnt;
        prev_busy = 1'b0;
        pulse_tick();
        for (int i = 0; i < 100; i++) begin
            if (bhs_cnt - bh == 2) break;
            prev_busy = busy;
            cyc();
        end
        check("jump_nb", bhs_cnt - bh, 2);
        check("jump_busy_before", prev_busy, 1'b1);
        check("jump_busy_after", busy, 1'b0);
        wait_idle("jump_idle");
        check("jump_nwr", log_addr.size() - b, 2);
        check_wr("jump_w0", b + 0, 32'h4, 32'd50);
        check_wr("jump_w1", b + 1, 32'hC, 32'd7);

        // Slow AWREADY: AW held 4 cycles with a stable address, W accepted at once
        aw_delay = 3; w_delay = 0;
        set_tgt(2'd0, 32'd130);
        b = log_addr.size(); bh = bhs_cnt; a0 = aw_hi; w0 = w_hi; bad0 = addr_bad;
        run_tick("slow_idle");
        check("slow_aw_cycles", aw_hi - a0, 4);
        check("slow_w_cycles", w_hi - w0, 1);
        check("slow_addr_stable", addr_bad - bad0, 0);
        check("slow_nb", bhs_cnt - bh, 1);
        check_wr("slow_w0", b, 32'h0, 32'd130);
        aw_delay = 0;

        // SLVERR leaves cur unchanged; next tick reissues the same value
        bresp_cfg = 2'b10;
        set_tgt(2'd2, 32'd40);
        b = log_addr.size();
        run_tick("slverr_idle");
        check("slverr_flag", bresp_err, 1'b1);
        check_wr("slverr_w0", b, 32'h8, 32'd40);
        bresp_cfg = 2'b00;
        run_tick("retry_idle");
        check("retry_nwr", log_addr.size() - b, 2);
        check_wr("retry_w0", b + 1, 32'h8, 32'd40);
        check("retry_flag_sticky", bresp_err, 1'b1);
        err_clr = 1'b1; cyc(); err_clr = 1'b0;
        check("errclr_flag", bresp_err, 1'b0);
        run_tick("retry2_idle");
        check("retry2_nowr", log_addr.size() - b, 2);

        // Target change on the in-flight channel does not disturb WDATA
        aw_delay = 3; w_delay = 3;
        set_tgt(2'd1, 32'd80);
        b = log_addr.size();
        pulse_tick();
        wait_aw("inflight_aw");
        set_tgt(2'd1, 32'd90);
        wait_idle("inflight_idle");
        check_wr("inflight_w0", b, 32'h4, 32'd80);
        run_tick("inflight2_idle");
        check_wr("inflight_w1", b + 1, 32'h4, 32'd90);

        // Ramp down with a dropped tick; set beats a simultaneous err_clr
        set_tgt(2'd0, 32'd100);
        run_tick("down_prep_idle");
        check("ovr_before", overrun, 1'b0);
        step = 16'd45;
        set_tgt(2'd0, 32'd10);
        b = log_addr.size();
        pulse_tick();
        wait_aw("down_aw");
        tick = 1'b1; err_clr = 1'b1;
        cyc();
        tick = 1'b0; err_clr = 1'b0;
        check("ovr_set_wins", overrun, 1'b1);
        wait_idle("down_idle");
        check("down_nwr", log_addr.size() - b, 1);
        check_wr("down_w0", b, 32'h0, 32'd55);
        err_clr = 1'b1; cyc(); err_clr = 1'b0;
        check("ovr_clr", overrun, 1'b0);
        run_tick("down2_idle");
        check_wr("down_w1", b + 1, 32'h0, 32'd10);
        run_tick("down3_idle");
        check("down_done_nwr", log_addr.size() - b, 2);

        // Reset while AWVALID is pending
        set_tgt(2'd3, 32'd99);
        pulse_tick();
        wait_aw("abort_aw");
        ARESETN = 1'b0;
        #1;
        check("abort_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 3'b000);
        check("abort_busy", busy, 1'b0);
        check("abort_addr_data", {M_AXI_AWADDR, M_AXI_WDATA}, 64'h0);
        check("abort_flags", {bresp_err, overrun}, 2'b00);
        aw_delay = 0; w_delay = 0;
        step = 16'd0;
        repeat (2) cyc();
        ARESETN = 1'b1;
        b = log_addr.size(); a0 = aw_hi;
        repeat (20) cyc();
        check("post_rst_no_aw", aw_hi - a0, 0);
        check("post_rst_no_wr", log_addr.size() - b, 0);
        run_tick("post_rst_idle");
        check("post_rst_tick_nowr", log_addr.size() - b, 0);
        set_tgt(2'd0, 32'd5);
        run_tick("post_rst2_idle");
        check("post_rst_nwr", log_addr.size() - b, 1);
        check_wr("post_rst_w0", b, 32'h0, 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_sequencer.md
PWM_RAMP_SEQUENCER -- requirements
Module: pwm_ramp_sequencer

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32: AXI4-Lite master address width.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32: AXI4-Lite master data width and duty width.
REQ-003 SHALL have parameter C_PWM_BASEADDR, default 32'h0000_0000: PWM slave base address; channel n register at base + 4*n, n = 0..3.
REQ-004 SHALL have ports:
- ACLK  in  1  clock; all logic rising-edge.
- ARESETN  in  1  asynchronous active-low reset.
- tgt_valid  in  1  new target offered.
- tgt_ready  out  1  target accepted when high with tgt_valid.
- tgt_ch  in  2  target channel.
- tgt_duty  in  32  target duty value.
- step  in  16  max duty change per write; 0 = jump to target.
- tick  in  1  one-cycle ramp-update strobe.
- err_clr  in  1  clears sticky flags.
- busy  out  1  high when state is not IDLE.
- bresp_err  out  1  sticky, a write returned BRESP != OKAY.
- overrun  out  1  sticky, tick arrived while busy.
- M_AXI_AWADDR  out  C_M_AXI_ADDR_WIDTH; M_AXI_AWPROT  out  3 (always 3'b000); M_AXI_AWVALID  out  1; M_AXI_AWREADY  in  1.
- M_AXI_WDATA  out  C_M_AXI_DATA_WIDTH; M_AXI_WSTRB  out  4 (always 4'hF); M_AXI_WVALID  out  1; M_AXI_WREADY  in  1.
- M_AXI_BRESP  in  2; M_AXI_BVALID  in  1; M_AXI_BREADY  out  1.

Function
REQ-005 SHALL hold per channel cur[n] (last value written with OKAY) and tgt[n], both 32 bits, unsigned.
REQ-006 SHALL tie tgt_ready high; on tgt_valid, tgt[tgt_ch] <= tgt_duty at the next edge, in any state.
REQ-007 SHALL implement states IDLE, SCAN, WRITE, RESP.
REQ-008 IDLE: on tick, go to SCAN with ch_idx = 0 next cycle.
REQ-009 SCAN (one cycle per channel): if cur[ch_idx] == tgt[ch_idx], advance ch_idx, or go to IDLE after channel 3; else latch nxt and go to WRITE.
REQ-010 nxt SHALL be tgt if step == 0 or |tgt - cur| <= step, else cur + step (tgt > cur) or cur - step (tgt < cur); arithmetic in 33 bits, no wrap.
REQ-011 WRITE: AWVALID and WVALID rise together on entry; AWADDR = base + 4*ch_idx, WDATA = nxt; each VALID drops independently after its handshake; go to RESP once both handshakes are done, including same-cycle ones.
REQ-012 AWADDR, WDATA, AWVALID and WVALID SHALL stay stable until the handshake.
REQ-013 RESP: BREADY high; on BVALID with BRESP == 2'b00, cur[ch_idx] <= nxt; otherwise cur is unchanged and bresp_err is set. Either way advance to the next channel in SCAN, or go to IDLE after channel 3.
REQ-014 A tgt update to the in-flight channel SHALL NOT alter the in-flight WDATA; it takes effect at the next tick.
REQ-015 A tick while state != IDLE SHALL be dropped and set overrun.
REQ-016 err_clr SHALL clear bresp_err and overrun; if err_clr and a setting event occur in the same cycle, set wins.
REQ-017 Each tick SHALL move every channel at most one step; there is at most one outstanding write.

Reset
REQ-018 While ARESETN is low: state IDLE, ch_idx 0, cur = tgt = 0 for all channels, AWVALID = WVALID = BREADY = 0, busy = bresp_err = overrun = 0, AWADDR = WDATA = 0.
REQ-019 Reset during WRITE or RESP SHALL abort immediately, with no pending write retried after release.

Verification
REQ-020 tgt ch0 = 100, step 30, slave always ready/OKAY, 4 ticks spaced 20 cycles -> writes at 0x0 of 30, 60, 90, 100; 5th tick -> no write.
REQ-021 tgt ch1 = 50 and ch3 = 7, step 0, one tick -> exactly two writes, 0x4 = 50 then 0xC = 7; busy drops in the cycle after the second BVALID.
REQ-022 Slave delays AWREADY 3 cycles and WREADY 0 cycles -> WVALID drops after 1 cycle, AWVALID held 4 cycles with a stable address, single B handshake.
REQ-023 BRESP = SLVERR on a ch2 write of 40 -> bresp_err = 1, cur[2] stays 0, next tick reissues 40; err_clr -> flag 0.
REQ-024 tick asserted during WRITE -> overrun = 1, no extra scan; ramp down from cur 100 to tgt 10 with step 45 -> writes 55, then 10.
REQ-025 ARESETN low while AWVALID is pending -> all outputs at reset values within the same cycle; no AXI activity after release until a tick.
